instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Fetch stage of the single-cycle CPU: owns the PC, issues word reads to instruction memory over a req/ack handshake, and presents one 32-bit instruction at a time to the general controller/decoder. When the decoder retires an instruction, the unit computes the next PC from the redirect controls. Redirect sources are sequential, branch, jump and jump-register, using the decoder's imm16/imm26 fields and the rs register value. A misaligned jump-register target stops fetch and raises a sticky fault.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset; must be word-aligned.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  read request; held high until imem_ack.
- imem_addr  out  32  byte address of the word to read; always equals pc.
- imem_ack  in  1  read complete; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction; reset 32'h0.
- instr_valid  out  1  instr is presented to the decoder; reset 0.
- stall  in  1  decoder not ready to retire; holds instr while high.
- pc  out  32  address of instr; reset RESET_PC.
- pc_plus4  out  32  pc + 4 (mod 2^32).
- npc_sel  in  2  redirect select: 00 SEQ, 01 BRANCH, 10 JUMP, 11 JR.
- branch_taken  in  1  qualifies BRANCH.
- imm16  in  16  branch offset field.
- imm26  in  26  jump index field.
- rs_data  in  32  JR target.
- fault  out  1  sticky misaligned-JR fault; reset 0.

## Operation
- States: FETCH, ISSUE, FAULT. Reset state: FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, capture imem_rdata into instr and move to ISSUE. imem_ack outside FETCH is ignored.
- ISSUE: instr_valid=1, imem_req=0. A retire is any cycle with stall=0. Redirect inputs are sampled only on the retire cycle.
- On retire, compute next_pc, load it into pc, and return to FETCH. While stall=1, instr and pc hold.
- next_pc by npc_sel:
  - SEQ: pc_plus4.
  - BRANCH: if branch_taken, pc_plus4 + (sign_extend(imm16) << 2), 32-bit wrap; otherwise pc_plus4.
  - JUMP: {pc_plus4[31:28], imm26, 2'b00}.
  - JR: rs_data.
- pc_plus4 wraps: pc=32'hFFFF_FFFC gives 32'h0000_0000.
- FAULT: on retire with JR and rs_data[1:0]≠0, pc loads rs_data unchanged. fault rises next cycle and the unit enters FAULT.
  - In FAULT: imem_req=0, instr_valid=0, pc frozen. The only exit is rst_n.
- Reset mid-operation: all state clears immediately and an in-flight request is abandoned. After release, fetch restarts at RESET_PC.

## Timing
- Zero-wait memory (ack in the same cycle as req) gives FETCH 1 cycle and ISSUE ≥1 cycle, i.e. 2 cycles per instruction minimum.
- Each memory wait cycle adds one FETCH cycle.
- instr_valid rises the cycle after the ack edge.
- pc updates on the retire edge. imem_req rises combinationally in the following FETCH cycle with the new pc.
- First request is asserted in the first cycle after rst_n deasserts.
- All outputs are registered except imem_req, imem_addr and pc_plus4, which are decoded from state and pc.

## Configuration
- IFU_JR_EN defined: JR redirect and the misaligned-target fault are implemented as above.
- IFU_JR_EN undefined:
  - npc_sel=11 behaves as SEQ and rs_data is unused.
  - fault is tied 0 and FAULT is unreachable.

## Structure
- ifu_pkg holds:
  - npc_sel encodings NPC_SEQ/NPC_BRANCH/NPC_JUMP/NPC_JR.
  - The state enum.
  - DEFAULT_RESET_PC.
- Sub-module npc_calc is purely combinational: inputs pc_plus4, npc_sel, branch_taken, imm16, imm26, rs_data; outputs next_pc and misaligned. The FSM and registers stay in instr_fetch_unit.

## Test plan
- Reset release with ack tied high:
  - imem_addr sequence 3000, 3004, 3008.
  - instr_valid pulses every 2nd cycle with stall=0.
- Ack delayed 3 cycles:
  - imem_req is held for 4 cycles at the same address.
  - instr equals imem_rdata captured at ack; instr_valid follows one cycle later.
- At pc=3010, BRANCH taken with imm16=16'hFFFC: next fetch is 3004. With branch_taken=0: next fetch is 3014.
- At pc=3000, JUMP imm26=26'h0000C10: next imem_addr is 0000_3040.
- stall high for 5 cycles in ISSUE:
  - instr and pc are stable and no imem_req.
  - A redirect input changing during the stall is ignored; only the retire-cycle value is used.
- With IFU_JR_EN, JR rs_data=32'h0000_3002:
  - fault=1 and imem_req stays 0.
  - rst_n low then high: fetch resumes at 3000 with fault=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional JR redirect is enabled by defining IFU_JR_EN.
package ifu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_sel_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_ISSUE = 2'b01,
        S_FAULT = 2'b10
    } ifu_state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection for the fetch unit.
// JR and the misaligned-target flag exist only when IFU_JR_EN is defined.
module npc_calc
    import ifu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [1:0]  npc_sel,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] branch_off;

    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

`ifndef IFU_JR_EN
    logic unused_rs;
    assign unused_rs = ^rs_data;
`endif

    always_comb begin
        next_pc    = pc_plus4;
        misaligned = 1'b0;
        case (npc_sel_t'(npc_sel))
            NPC_BRANCH: begin
                if (branch_taken) begin
                    next_pc = pc_plus4 + branch_off;
                end
            end
            NPC_JUMP: next_pc = {pc_plus4[31:28], imm26, 2'b00};
`ifdef IFU_JR_EN
            NPC_JR: begin
                next_pc    = rs_data;
                misaligned = (rs_data[1:0] != 2'b00);
            end
`endif
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and holds one instruction for the decoder.
// Define IFU_JR_EN to enable jump-register redirects and the sticky misaligned-JR fault.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  npc_sel,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    output logic        fault
);

    ifu_state_t  state;
    logic [31:0] next_pc;
    logic        misaligned;

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    npc_calc u_npc_calc (
        .pc_plus4     (pc_plus4),
        .npc_sel      (npc_sel),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .imm26        (imm26),
        .rs_data      (rs_data),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    // misaligned is constant 0 without IFU_JR_EN, so fault and S_FAULT fold away
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        if (misaligned) begin
                            fault <= 1'b1;
                            state <= S_FAULT;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
